// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU, the video fetch unit, the two byte-wide memory banks and mem_arbiter.
// The slave modport is the arbiter's view; master is the view of everything around it.
interface mem_arbiter_if;
   logic        cpu_req;
   logic        cpu_wr;
   logic        cpu_wide;
   logic [15:0] cpu_addr;
   logic [15:0] cpu_wdata;
   logic        cpu_ack;
   logic        cpu_rvalid;
   logic [15:0] cpu_rdata;

   logic        vid_req;
   logic [14:0] vid_addr;
   logic        vid_ack;
   logic        vid_rvalid;
   logic [15:0] vid_rdata;

   logic [14:0] bank0_addr;
   logic [14:0] bank1_addr;
   logic        bank0_we;
   logic        bank1_we;
   logic [7:0]  bank0_wdata;
   logic [7:0]  bank1_wdata;
   logic [7:0]  bank0_rdata;
   logic [7:0]  bank1_rdata;

   modport slave (
      input  cpu_req, cpu_wr, cpu_wide, cpu_addr, cpu_wdata,
      output cpu_ack, cpu_rvalid, cpu_rdata,
      input  vid_req, vid_addr,
      output vid_ack, vid_rvalid, vid_rdata,
      output bank0_addr, bank1_addr, bank0_we, bank1_we, bank0_wdata, bank1_wdata,
      input  bank0_rdata, bank1_rdata
   );

   modport master (
      output cpu_req, cpu_wr, cpu_wide, cpu_addr, cpu_wdata,
      input  cpu_ack, cpu_rvalid, cpu_rdata,
      output vid_req, vid_addr,
      input  vid_ack, vid_rvalid, vid_rdata,
      input  bank0_addr, bank1_addr, bank0_we, bank1_we, bank0_wdata, bank1_wdata,
      output bank0_rdata, bank1_rdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// Shares the even/odd byte banks between the CPU and video fetch; video has priority,
// but only for a bounded run of grants while the CPU is waiting.
module mem_arbiter #(
   parameter int MAX_VID_RUN = 4
) (
   input  logic          clk,
   input  logic          reset,
   mem_arbiter_if.slave  bus
);

   typedef enum logic {OWNER_CPU, OWNER_VID} owner_t;

   localparam logic [3:0] RUN_MAX = 4'(MAX_VID_RUN);

   logic [3:0]  run_cnt;
   logic        grant_vid;
   logic        grant_cpu;
   logic        pend_valid;
   owner_t      pend_owner;
   logic        pend_wide;
   logic        pend_odd;
   logic        cpu_rvalid_w;
   logic        vid_rvalid_w;
   logic [15:0] rd_word;
   logic [15:0] cpu_rdata_q;
   logic [15:0] vid_rdata_q;
   logic [14:0] cpu_row;
   logic [14:0] cpu_row_inc;
   logic [14:0] b0_addr;
   logic [14:0] b1_addr;
   logic        b0_we;
   logic        b1_we;
   logic [7:0]  b0_wd;
   logic [7:0]  b1_wd;

   // Video wins a contested cycle until it has taken MAX_VID_RUN grants in a row against a waiting CPU.
   always_comb begin
      grant_vid = 1'b0;
      grant_cpu = 1'b0;
      if (!reset) begin
         if (bus.vid_req && (!bus.cpu_req || run_cnt != RUN_MAX)) begin
            grant_vid = 1'b1;
         end else if (bus.cpu_req) begin
            grant_cpu = 1'b1;
         end
      end
   end

   assign cpu_row     = bus.cpu_addr[15:1];
   assign cpu_row_inc = cpu_row + 15'd1;

   // An odd-aligned wide access puts its high byte in the next even byte, i.e. bank0 one row up.
   always_comb begin
      b0_addr = '0;
      b1_addr = '0;
      b0_we   = 1'b0;
      b1_we   = 1'b0;
      b0_wd   = '0;
      b1_wd   = '0;
      if (grant_vid) begin
         b0_addr = bus.vid_addr;
         b1_addr = bus.vid_addr;
      end else if (grant_cpu) begin
         case ({bus.cpu_wide, bus.cpu_addr[0]})
            2'b00: begin
               b0_addr = cpu_row;
               b0_we   = bus.cpu_wr;
               b0_wd   = bus.cpu_wdata[7:0];
            end
            2'b01: begin
               b1_addr = cpu_row;
               b1_we   = bus.cpu_wr;
               b1_wd   = bus.cpu_wdata[7:0];
            end
            2'b10: begin
               b0_addr = cpu_row;
               b0_we   = bus.cpu_wr;
               b0_wd   = bus.cpu_wdata[7:0];
               b1_addr = cpu_row;
               b1_we   = bus.cpu_wr;
               b1_wd   = bus.cpu_wdata[15:8];
            end
            default: begin
               b1_addr = cpu_row;
               b1_we   = bus.cpu_wr;
               b1_wd   = bus.cpu_wdata[7:0];
               b0_addr = cpu_row_inc;
               b0_we   = bus.cpu_wr;
               b0_wd   = bus.cpu_wdata[15:8];
            end
         endcase
      end
   end

   always_comb begin
      case ({pend_wide, pend_odd})
         2'b00:   rd_word = {8'h00, bus.bank0_rdata};
         2'b01:   rd_word = {8'h00, bus.bank1_rdata};
         2'b10:   rd_word = {bus.bank1_rdata, bus.bank0_rdata};
         default: rd_word = {bus.bank0_rdata, bus.bank1_rdata};
      endcase
   end

   // Reset masks a response that was already in flight when it arrived.
   assign cpu_rvalid_w = pend_valid && (pend_owner == OWNER_CPU) && !reset;
   assign vid_rvalid_w = pend_valid && (pend_owner == OWNER_VID) && !reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         run_cnt     <= '0;
         pend_valid  <= 1'b0;
         pend_owner  <= OWNER_CPU;
         pend_wide   <= 1'b0;
         pend_odd    <= 1'b0;
         cpu_rdata_q <= '0;
         vid_rdata_q <= '0;
      end else begin
         if (!bus.cpu_req || grant_cpu) begin
            run_cnt <= '0;
         end else if (grant_vid && run_cnt != RUN_MAX) begin
            run_cnt <= run_cnt + 4'd1;
         end
         pend_valid <= grant_vid || (grant_cpu && !bus.cpu_wr);
         pend_owner <= grant_vid ? OWNER_VID : OWNER_CPU;
         pend_wide  <= grant_vid || bus.cpu_wide;
         pend_odd   <= grant_cpu && bus.cpu_addr[0];
         if (cpu_rvalid_w) begin
            cpu_rdata_q <= rd_word;
         end
         if (vid_rvalid_w) begin
            vid_rdata_q <= rd_word;
         end
      end
   end

   assign bus.cpu_ack     = grant_cpu;
   assign bus.vid_ack     = grant_vid;
   assign bus.cpu_rvalid  = cpu_rvalid_w;
   assign bus.vid_rvalid  = vid_rvalid_w;
   assign bus.cpu_rdata   = reset ? 16'h0000 : (cpu_rvalid_w ? rd_word : cpu_rdata_q);
   assign bus.vid_rdata   = reset ? 16'h0000 : (vid_rvalid_w ? rd_word : vid_rdata_q);
   assign bus.bank0_addr  = b0_addr;
   assign bus.bank1_addr  = b1_addr;
   assign bus.bank0_we    = b0_we;
   assign bus.bank1_we    = b1_we;
   assign bus.bank0_wdata = b0_wd;
   assign bus.bank1_wdata = b1_wd;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: two byte banks modelled as one flat byte array,
// checked against a flat byte-addressed reference memory and the arbitration rules.
module tb_mem_arbiter;

   localparam int MAX_VID_RUN = 4;

   typedef struct packed {
      logic [14:0] a0;
      logic        we0;
      logic [7:0]  d0;
      logic [14:0] a1;
      logic        we1;
      logic [7:0]  d1;
   } snap_t;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   bit   mem_ready = 1'b0;

   logic [7:0] mem     [0:65535];
   logic [7:0] ref_mem [0:65535];

   mem_arbiter_if bus ();

   mem_arbiter #(.MAX_VID_RUN(MAX_VID_RUN)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Bank model: byte address {row, bank}; synchronous read data one cycle after the address.
   initial begin
      bus.bank0_rdata = 8'h00;
      bus.bank1_rdata = 8'h00;
      wait (mem_ready);
      for (int i = 0; i < 65536; i++) mem[i] = ref_mem[i];
      forever begin
         @(posedge clk);
         if (bus.bank0_we) mem[{bus.bank0_addr, 1'b0}] <= bus.bank0_wdata;
         if (bus.bank1_we) mem[{bus.bank1_addr, 1'b1}] <= bus.bank1_wdata;
         bus.bank0_rdata <= mem[{bus.bank0_addr, 1'b0}];
         bus.bank1_rdata <= mem[{bus.bank1_addr, 1'b1}];
      end
   end

   function automatic logic [15:0] ref_read(input logic wide, input logic [15:0] a);
      logic [15:0] a1;
      a1 = a + 16'd1;
      return wide ? {ref_mem[a1], ref_mem[a]} : {8'h00, ref_mem[a]};
   endfunction

   function automatic logic [15:0] ref_vid(input logic [14:0] w);
      return {ref_mem[{w, 1'b1}], ref_mem[{w, 1'b0}]};
   endfunction

   task automatic ref_write(input logic wide, input logic [15:0] a, input logic [15:0] d);
      logic [15:0] a1;
      a1 = a + 16'd1;
      ref_mem[a] = d[7:0];
      if (wide) ref_mem[a1] = d[15:8];
   endtask

   // Issues one CPU access, waits (bounded) for its ack, then samples the response cycle.
   task automatic cpu_op(input logic wr, input logic wide, input logic [15:0] addr,
                         input logic [15:0] wdata, output bit acked, output snap_t snap,
                         output logic rv, output logic [15:0] rd);
      int waited;
      waited = 0;
      acked  = 1'b0;
      snap   = '0;
      @(posedge clk); #1;
      bus.cpu_req   = 1'b1;
      bus.cpu_wr    = wr;
      bus.cpu_wide  = wide;
      bus.cpu_addr  = addr;
      bus.cpu_wdata = wdata;
      while (!acked && waited < 16) begin
         @(negedge clk);
         if (bus.cpu_ack === 1'b1) begin
            acked    = 1'b1;
            snap.a0  = bus.bank0_addr;
            snap.we0 = bus.bank0_we;
            snap.d0  = bus.bank0_wdata;
            snap.a1  = bus.bank1_addr;
            snap.we1 = bus.bank1_we;
            snap.d1  = bus.bank1_wdata;
            if (wr) ref_write(wide, addr, wdata);
         end
         waited++;
      end
      @(posedge clk); #1;
      bus.cpu_req = 1'b0;
      @(negedge clk);
      rv = bus.cpu_rvalid;
      rd = bus.cpu_rdata;
   endtask

   task automatic test_reset();
      reset       = 1'b1;
      bus.cpu_req = 1'b1;
      bus.cpu_wr  = 1'b0;
      bus.cpu_addr = 16'h1234;
      bus.vid_req = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({bus.cpu_ack, bus.vid_ack} !== 2'b00) begin
         errors++;
         $display("[TB] FAIL reset_acks: got %b expected 00", {bus.cpu_ack, bus.vid_ack});
      end
      checks++;
      if ({bus.cpu_rvalid, bus.vid_rvalid, bus.bank0_we, bus.bank1_we} !== 4'b0000) begin
         errors++;
         $display("[TB] FAIL reset_strobes: got %b expected 0000",
                  {bus.cpu_rvalid, bus.vid_rvalid, bus.bank0_we, bus.bank1_we});
      end
      checks++;
      if ({bus.cpu_rdata, bus.vid_rdata} !== 32'h0) begin
         errors++;
         $display("[TB] FAIL reset_rdata: got %h expected 0", {bus.cpu_rdata, bus.vid_rdata});
      end
      checks++;
      if ({bus.bank0_addr, bus.bank1_addr} !== 30'h0) begin
         errors++;
         $display("[TB] FAIL reset_addr: got %h expected 0", {bus.bank0_addr, bus.bank1_addr});
      end
      @(posedge clk); #1;
      bus.cpu_req = 1'b0;
      bus.vid_req = 1'b0;
      reset       = 1'b0;
   endtask

   task automatic test_wide_word();
      bit          acked;
      snap_t       s;
      logic        rv;
      logic [15:0] rd;
      cpu_op(1'b1, 1'b1, 16'h0100, 16'h1234, acked, s, rv, rd);
      checks++;
      if (!acked || s !== {15'h0080, 1'b1, 8'h34, 15'h0080, 1'b1, 8'h12}) begin
         errors++;
         $display("[TB] FAIL wide_write_banks: acked %0d got %h expected %h", acked, s,
                  {15'h0080, 1'b1, 8'h34, 15'h0080, 1'b1, 8'h12});
      end
      checks++;
      if ({mem[16'h0100], mem[16'h0101]} !== 16'h3412 || rv !== 1'b0) begin
         errors++;
         $display("[TB] FAIL wide_write_mem: got %h rvalid %b expected 3412 rvalid 0",
                  {mem[16'h0100], mem[16'h0101]}, rv);
      end
      cpu_op(1'b0, 1'b1, 16'h0100, 16'h0000, acked, s, rv, rd);
      checks++;
      if (!acked || rv !== 1'b1 || rd !== ref_read(1'b1, 16'h0100)) begin
         errors++;
         $display("[TB] FAIL wide_read: acked %0d rvalid %b got %h expected %h", acked, rv, rd,
                  ref_read(1'b1, 16'h0100));
      end
      @(negedge clk);
      checks++;
      if (bus.cpu_rvalid !== 1'b0 || bus.cpu_rdata !== 16'h1234) begin
         errors++;
         $display("[TB] FAIL rdata_hold: rvalid %b got %h expected 1234", bus.cpu_rvalid, bus.cpu_rdata);
      end
   endtask

   task automatic test_byte_odd();
      bit          acked;
      snap_t       s;
      logic        rv;
      logic [15:0] rd;
      cpu_op(1'b1, 1'b0, 16'h0101, 16'h55AB, acked, s, rv, rd);
      checks++;
      if (!acked || s.we0 !== 1'b0 || s.we1 !== 1'b1 || s.a1 !== 15'h0080 || s.d1 !== 8'hAB) begin
         errors++;
         $display("[TB] FAIL byte_odd_write: acked %0d got %h", acked, s);
      end
      cpu_op(1'b0, 1'b0, 16'h0101, 16'h0000, acked, s, rv, rd);
      checks++;
      if (!acked || rv !== 1'b1 || rd !== ref_read(1'b0, 16'h0101)) begin
         errors++;
         $display("[TB] FAIL byte_odd_read: rvalid %b got %h expected %h", rv, rd,
                  ref_read(1'b0, 16'h0101));
      end
      cpu_op(1'b0, 1'b0, 16'h0100, 16'h0000, acked, s, rv, rd);
      checks++;
      if (!acked || rv !== 1'b1 || rd !== ref_read(1'b0, 16'h0100)) begin
         errors++;
         $display("[TB] FAIL byte_even_read: rvalid %b got %h expected %h", rv, rd,
                  ref_read(1'b0, 16'h0100));
      end
   endtask

   task automatic test_odd_wrap();
      bit          acked;
      snap_t       s;
      logic        rv;
      logic [15:0] rd;
      cpu_op(1'b1, 1'b1, 16'hFFFF, 16'hBEEF, acked, s, rv, rd);
      checks++;
      if (!acked || s !== {15'h0000, 1'b1, 8'hBE, 15'h7FFF, 1'b1, 8'hEF}) begin
         errors++;
         $display("[TB] FAIL odd_wrap_write: acked %0d got %h expected %h", acked, s,
                  {15'h0000, 1'b1, 8'hBE, 15'h7FFF, 1'b1, 8'hEF});
      end
      cpu_op(1'b0, 1'b1, 16'hFFFF, 16'h0000, acked, s, rv, rd);
      checks++;
      if (!acked || rv !== 1'b1 || rd !== ref_read(1'b1, 16'hFFFF)) begin
         errors++;
         $display("[TB] FAIL odd_wrap_read: rvalid %b got %h expected %h", rv, rd,
                  ref_read(1'b1, 16'hFFFF));
      end
   endtask

   task automatic test_fairness();
      int          prev;
      logic [15:0] exp;
      logic        exp_cpu;
      prev = 0;
      exp  = '0;
      @(posedge clk); #1;
      bus.cpu_req  = 1'b1;
      bus.cpu_wr   = 1'b0;
      bus.cpu_wide = 1'b1;
      bus.vid_req  = 1'b1;
      for (int k = 0; k < 21; k++) begin
         if (k < 20) begin
            bus.cpu_addr = 16'($urandom);
            bus.vid_addr = 15'($urandom);
         end else begin
            bus.cpu_req = 1'b0;
            bus.vid_req = 1'b0;
         end
         @(negedge clk);
         if (prev == 1) begin
            checks++;
            if (bus.cpu_rvalid !== 1'b1 || bus.vid_rvalid !== 1'b0 || bus.cpu_rdata !== exp) begin
               errors++;
               $display("[TB] FAIL fair_cpu_resp: rvalid %b got %h expected %h", bus.cpu_rvalid,
                        bus.cpu_rdata, exp);
            end
         end else if (prev == 2) begin
            checks++;
            if (bus.vid_rvalid !== 1'b1 || bus.cpu_rvalid !== 1'b0 || bus.vid_rdata !== exp) begin
               errors++;
               $display("[TB] FAIL fair_vid_resp: rvalid %b got %h expected %h", bus.vid_rvalid,
                        bus.vid_rdata, exp);
            end
         end
         if (k < 20) begin
            exp_cpu = ((k % (MAX_VID_RUN + 1)) == MAX_VID_RUN);
            checks++;
            if ({bus.cpu_ack, bus.vid_ack} !== {exp_cpu, !exp_cpu}) begin
               errors++;
               $display("[TB] FAIL fair_grant_%0d: got cpu/vid %b expected %b", k,
                        {bus.cpu_ack, bus.vid_ack}, {exp_cpu, !exp_cpu});
            end
            if (exp_cpu) begin
               prev = 1;
               exp  = ref_read(1'b1, bus.cpu_addr);
            end else begin
               prev = 2;
               exp  = ref_vid(bus.vid_addr);
            end
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic test_back_to_back();
      @(posedge clk); #1;
      bus.vid_req  = 1'b1;
      bus.vid_addr = 15'h7000;
      @(negedge clk);
      checks++;
      if (bus.vid_ack !== 1'b1 || bus.bank0_addr !== 15'h7000 || bus.bank1_addr !== 15'h7000) begin
         errors++;
         $display("[TB] FAIL b2b_first: ack %b addr %h/%h expected 1 7000/7000", bus.vid_ack,
                  bus.bank0_addr, bus.bank1_addr);
      end
      @(posedge clk); #1;
      bus.vid_addr = 15'h7001;
      @(negedge clk);
      checks++;
      if (bus.vid_ack !== 1'b1 || bus.vid_rvalid !== 1'b1 || bus.vid_rdata !== ref_vid(15'h7000)) begin
         errors++;
         $display("[TB] FAIL b2b_second: ack %b rvalid %b got %h expected %h", bus.vid_ack,
                  bus.vid_rvalid, bus.vid_rdata, ref_vid(15'h7000));
      end
      @(posedge clk); #1;
      bus.vid_req = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.vid_ack !== 1'b0 || bus.vid_rvalid !== 1'b1 || bus.vid_rdata !== ref_vid(15'h7001)) begin
         errors++;
         $display("[TB] FAIL b2b_third: ack %b rvalid %b got %h expected %h", bus.vid_ack,
                  bus.vid_rvalid, bus.vid_rdata, ref_vid(15'h7001));
      end
   endtask

   task automatic test_reset_mid_read();
      bit          acked;
      snap_t       s;
      logic        rv;
      logic [15:0] rd;
      @(posedge clk); #1;
      bus.cpu_req  = 1'b1;
      bus.cpu_wr   = 1'b0;
      bus.cpu_wide = 1'b1;
      bus.cpu_addr = 16'h0100;
      @(negedge clk);
      checks++;
      if (bus.cpu_ack !== 1'b1) begin
         errors++;
         $display("[TB] FAIL rmr_ack: got %b expected 1", bus.cpu_ack);
      end
      @(posedge clk); #1;
      bus.cpu_req = 1'b0;
      reset       = 1'b1;
      @(negedge clk);
      checks++;
      if ({bus.cpu_rvalid, bus.vid_rvalid, bus.cpu_ack, bus.vid_ack, bus.bank0_we, bus.bank1_we} !== 6'b0
          || {bus.cpu_rdata, bus.vid_rdata} !== 32'h0 || {bus.bank0_addr, bus.bank1_addr} !== 30'h0) begin
         errors++;
         $display("[TB] FAIL rmr_outputs: rvalid %b rdata %h expected 0 0", bus.cpu_rvalid, bus.cpu_rdata);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.cpu_rvalid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL rmr_late_rvalid: got %b expected 0", bus.cpu_rvalid);
      end
      cpu_op(1'b0, 1'b1, 16'hFFFF, 16'h0000, acked, s, rv, rd);
      checks++;
      if (!acked || rv !== 1'b1 || rd !== ref_read(1'b1, 16'hFFFF)) begin
         errors++;
         $display("[TB] FAIL rmr_after: rvalid %b got %h expected %h", rv, rd, ref_read(1'b1, 16'hFFFF));
      end
   endtask

   task automatic test_random();
      int          run;
      int          kind;
      int          wait_cnt;
      int          max_wait;
      bit          cpu_pend;
      bit          vid_pend;
      logic        exp_cpu;
      logic        exp_vid;
      logic [15:0] exp;
      run = 0; kind = 0; wait_cnt = 0; max_wait = 0;
      cpu_pend = 1'b0; vid_pend = 1'b0; exp = '0;
      for (int c = 0; c < 401; c++) begin
         @(posedge clk); #1;
         if (c < 400) begin
            if (!cpu_pend && $urandom_range(0, 2) != 0) begin
               cpu_pend      = 1'b1;
               bus.cpu_wr    = 1'($urandom);
               bus.cpu_wide  = 1'($urandom);
               bus.cpu_addr  = 16'($urandom);
               bus.cpu_wdata = 16'($urandom);
            end
            if (!vid_pend && $urandom_range(0, 3) != 0) begin
               vid_pend     = 1'b1;
               bus.vid_addr = 15'($urandom);
            end
         end
         bus.cpu_req = cpu_pend;
         bus.vid_req = vid_pend;
         @(negedge clk);
         checks++;
         if ({bus.cpu_rvalid, bus.vid_rvalid} !== {kind == 1, kind == 2}
             || (kind == 1 && bus.cpu_rdata !== exp) || (kind == 2 && bus.vid_rdata !== exp)) begin
            errors++;
            $display("[TB] FAIL rand_resp_%0d: rvalid cpu/vid %b rdata %h/%h expected kind %0d data %h", c,
                     {bus.cpu_rvalid, bus.vid_rvalid}, bus.cpu_rdata, bus.vid_rdata, kind, exp);
         end
         exp_vid = vid_pend && (!cpu_pend || run < MAX_VID_RUN);
         exp_cpu = cpu_pend && !exp_vid;
         checks++;
         if ({bus.cpu_ack, bus.vid_ack} !== {exp_cpu, exp_vid}) begin
            errors++;
            $display("[TB] FAIL rand_grant_%0d: got cpu/vid %b expected %b", c,
                     {bus.cpu_ack, bus.vid_ack}, {exp_cpu, exp_vid});
         end
         if (cpu_pend && !exp_cpu) wait_cnt++;
         else wait_cnt = 0;
         if (wait_cnt > max_wait) max_wait = wait_cnt;
         if (!cpu_pend || exp_cpu) run = 0;
         else if (exp_vid && run < MAX_VID_RUN) run++;
         kind = 0;
         if (exp_cpu) begin
            if (bus.cpu_wr) begin
               ref_write(bus.cpu_wide, bus.cpu_addr, bus.cpu_wdata);
            end else begin
               kind = 1;
               exp  = ref_read(bus.cpu_wide, bus.cpu_addr);
            end
            cpu_pend = 1'b0;
         end
         if (exp_vid) begin
            kind     = 2;
            exp      = ref_vid(bus.vid_addr);
            vid_pend = 1'b0;
         end
      end
      checks++;
      if (max_wait > MAX_VID_RUN) begin
         errors++;
         $display("[TB] FAIL rand_cpu_wait: got %0d expected <= %0d", max_wait, MAX_VID_RUN);
      end
      @(posedge clk); #1;
      bus.cpu_req = 1'b0;
      bus.vid_req = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      reset         = 1'b1;
      bus.cpu_req   = 1'b0;
      bus.cpu_wr    = 1'b0;
      bus.cpu_wide  = 1'b0;
      bus.cpu_addr  = '0;
      bus.cpu_wdata = '0;
      bus.vid_req   = 1'b0;
      bus.vid_addr  = '0;
      for (int i = 0; i < 65536; i++) ref_mem[i] = 8'($urandom);
      mem_ready = 1'b1;
      test_reset();
      test_wide_word();
      test_byte_odd();
      test_odd_wrap();
      test_fairness();
      test_back_to_back();
      test_reset_mid_read();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the two byte-wide main-memory banks (bank0 = even bytes, bank1 = odd bytes) between the CPU and the video fetch unit. Video reads of VRAM have priority, with a bounded run length so the CPU cannot starve. Handles byte and 16-bit little-endian accesses, including odd-aligned wide accesses, in a single bank cycle. Sits in top between cpu, video and mem.

Parameters:
MAX_VID_RUN, 4, max consecutive video grants while a CPU request is pending (1..15)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cpu_req  in  1  CPU request; held with stable fields until cpu_ack
cpu_wr  in  1  1 = write, 0 = read
cpu_wide  in  1  1 = 16-bit access, 0 = byte access
cpu_addr  in  16  byte address
cpu_wdata  in  16  write data; a byte write uses [7:0]
cpu_ack  out  1  one-cycle pulse: request issued to the banks this cycle
cpu_rvalid  out  1  one-cycle pulse: cpu_rdata valid
cpu_rdata  out  16  read data; byte reads are zero-extended
vid_req  in  1  video read request; held until vid_ack
vid_addr  in  15  word address (always wide, even-aligned)
vid_ack  out  1  one-cycle grant pulse
vid_rvalid  out  1  one-cycle pulse: vid_rdata valid
vid_rdata  out  16  {bank1, bank0}
bank0_addr, bank1_addr  out  15  row address
bank0_we, bank1_we  out  1  write enable
bank0_wdata, bank1_wdata  out  8  write data
bank0_rdata, bank1_rdata  in  8  synchronous read data, valid the cycle after the address

Behaviour:
- Reset: all ack/rvalid/we low, rdata 0, bank addresses 0, run counter 0, pending-response register cleared. A read issued in the reset cycle or the cycle before produces no rvalid.
- At most one grant per cycle; back-to-back grants allowed (full throughput).
- Arbitration, evaluated each cycle on the raw request inputs:
  - vid_req only: grant video.
  - cpu_req only: grant CPU.
  - Both asserted: grant video unless run == MAX_VID_RUN, then grant CPU.
- Run counter: increments on a video grant while cpu_req is high, saturating at MAX_VID_RUN. Clears on a CPU grant or whenever cpu_req is low.
- A request whose ack pulsed this cycle counts as taken. The requester must drop req, or present a new request, the next cycle.
- The grant cycle drives the bank addresses and write enables combinationally from the granted request. There is no grant when idle: we = 0.
- CPU mapping, with a = cpu_addr, row = a[15:1]:
  - Byte, a[0]=0: bank0 row, data wdata[7:0].
  - Byte, a[0]=1: bank1 row, data wdata[7:0].
  - Wide, a[0]=0: bank0 row gets lo byte, bank1 row gets hi byte.
  - Wide, a[0]=1: bank1 row gets lo byte, bank0 row+1 gets hi byte. row+1 wraps 0x7FFF -> 0x0000.
  - Unused bank: we = 0.
- Video mapping: both banks at vid_addr, we = 0.
- Reads: the grant cycle registers the owner, wide and a[0]. The next cycle asserts the owner's rvalid and assembles rdata combinationally from the bank outputs:
  - Byte, even: {00, b0}.
  - Byte, odd: {00, b1}.
  - Wide, even: {b1, b0}.
  - Wide, odd: {b0, b1}.
  - rdata holds its last value while rvalid is low.
- Writes: complete at ack; no rvalid.
- Read latency: ack at cycle N, rvalid at N+1. This holds regardless of the grant at N+1.

Test Plan:
- CPU wide write 0x1234 @0x0100, then wide read @0x0100 -> bank0 row 0x80 = 0x34, bank1 row 0x80 = 0x12; ack cycle N+2 (write acked at N), cpu_rvalid cycle N+3 with rdata 0x1234.
- Byte write 0xAB @0x0101, byte read @0x0101 -> only bank1_we pulses; rdata 0x00AB.
- Odd wide write 0xBEEF @0xFFFF -> bank1 row 0x7FFF = 0xEF, bank0 row 0x0000 = 0xBE; wide read @0xFFFF returns 0xBEEF.
- vid_req and cpu_req held continuously, MAX_VID_RUN = 4 -> grant pattern V,V,V,V,C repeating. Counter clears after each CPU grant. No CPU wait exceeds 4 cycles.
- Back-to-back video reads at 0x7000, 0x7001 -> vid_ack on consecutive cycles; vid_rvalid on the following consecutive cycles with correct words.
- Reset asserted the cycle after a CPU read ack -> no cpu_rvalid. All outputs at reset values. The next request after reset is served normally.
